memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 136 +++++++++++++
 tb/tb_memory_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-master RAM arbiter: instruction and data caches share one RAM port.
// Define ARB_STARVE_GUARD_EN to bound how long data traffic can block instruction reads.
module memory_arbiter #(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [1:0]        grant
);

    localparam logic [1:0] RS_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_dreq;
    logic w_access;
    logic w_idone;
    logic w_ddone;
    logic w_force_i;

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == RS_ACCESS);
    assign w_idone  = (r_state == IGNT) && w_access;
    assign w_ddone  = (r_state == DGNT) && w_access;

    assign iload = ramload;
    assign dload = ramload;
    assign grant = r_state;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_starve_cnt;

    // Counts finished data transfers that an instruction read sat through.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_starve_cnt <= '0;
        end else if (w_idone) begin
            r_starve_cnt <= '0;
        end else if ((r_state == IDLE) && !iREN) begin
            r_starve_cnt <= '0;
        end else if (w_ddone && iREN && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_force_i = iREN && (r_starve_cnt == LIMIT);
`else
    assign w_force_i = 1'b0;

    // The limit only matters with the guard; keep a sanity hook on it.
    if (STARVE_LIMIT < 1) begin : g_limit_unused
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        if (RST) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_force_i) begin
                        w_next = IGNT;
                    end else if (w_dreq) begin
                        w_next = DGNT;
                    end else if (iREN) begin
                        w_next = IGNT;
                    end
                end
                IGNT: begin
                    ramREN  = iREN;
                    ramaddr = iaddr;
                    iwait   = !w_access;
                    if (!iREN || w_access) begin
                        w_next = IDLE;
                    end
                end
                DGNT: begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    dwait    = !w_access;
                    if (!w_dreq || w_access) begin
                        w_next = IDLE;
                    end
                end
                default: begin
                    w_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter.
// Expectations follow ARB_STARVE_GUARD_EN the same way the design does.
module tb_memory_arbiter;

    localparam int W = 32;

    logic         CLK;
    logic         RST;
    logic         iREN;
    logic [W-1:0] iaddr;
    logic         iwait;
    logic [W-1:0] iload;
    logic         dREN;
    logic         dWEN;
    logic [W-1:0] daddr;
    logic [W-1:0] dstore;
    logic         dwait;
    logic [W-1:0] dload;
    logic         ramREN;
    logic         ramWEN;
    logic [W-1:0] ramaddr;
    logic [W-1:0] ramstore;
    logic [W-1:0] ramload;
    logic [1:0]   ramstate;
    logic [1:0]   grant;

    int n_cmp;
    int n_err;

    memory_arbiter #(.WORD_W(W), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .grant(grant)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = 2'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST  = 1'b1;
        iREN = 1'b1;
        dREN = 1'b1;
        iaddr = 32'h44;
        daddr = 32'h88;
        ramstate = 2'd2;
        tick();
        tick();
        n_cmp++;
        if (grant !== 2'b00) begin
            n_err++;
            $display("FAIL rst_grant: got %b want 00", grant);
        end
        n_cmp++;
        if (iwait !== 1'b1) begin
            n_err++;
            $display("FAIL rst_iwait: got %b want 1", iwait);
        end
        n_cmp++;
        if (dwait !== 1'b1) begin
            n_err++;
            $display("FAIL rst_dwait: got %b want 1", dwait);
        end
        n_cmp++;
        if ({ramREN, ramWEN} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_en: got %b want 00", {ramREN, ramWEN});
        end
        n_cmp++;
        if (ramaddr !== 32'h0) begin
            n_err++;
            $display("FAIL rst_addr: got %h want 0", ramaddr);
        end
        n_cmp++;
        if (ramstore !== 32'h0) begin
            n_err++;
            $display("FAIL rst_store: got %h want 0", ramstore);
        end
        idle_inputs();
        RST = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 2'b00) begin
            n_err++;
            $display("FAIL post_rst_grant: got %b want 00", grant);
        end
    endtask

    task automatic test_iread();
        iREN     = 1'b1;
        iaddr    = 32'h40;
        ramstate = 2'd2;
        ramload  = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (grant !== 2'b00 || iwait !== 1'b1) begin
            n_err++;
            $display("FAIL iread_pre: got grant=%b iwait=%b want 00/1",
                     grant, iwait);
        end
        tick();
        n_cmp++;
        if (grant !== 2'b01) begin
            n_err++;
            $display("FAIL iread_grant: got %b want 01", grant);
        end
        n_cmp++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin
            n_err++;
            $display("FAIL iread_ram: got ren=%b wen=%b addr=%h want 1/0/40",
                     ramREN, ramWEN, ramaddr);
        end
        n_cmp++;
        if (iwait !== 1'b0 || dwait !== 1'b1) begin
            n_err++;
            $display("FAIL iread_wait: got i=%b d=%b want 0/1", iwait, dwait);
        end
        n_cmp++;
        if (iload !== 32'hDEADBEEF || dload !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL iread_load: got i=%h d=%h want deadbeef",
                     iload, dload);
        end
        tick();
        n_cmp++;
        if (grant !== 2'b00) begin
            n_err++;
            $display("FAIL iread_idle: got %b want 00", grant);
        end
        iREN = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        iREN     = 1'b1;
        iaddr    = 32'h44;
        dWEN     = 1'b1;
        daddr    = 32'h80;
        dstore   = 32'h1234;
        ramstate = 2'd2;
        tick();
        n_cmp++;
        if (grant !== 2'b10) begin
            n_err++;
            $display("FAIL prio_dgnt: got %b want 10", grant);
        end
        n_cmp++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin
            n_err++;
            $display("FAIL prio_en: got wen=%b ren=%b want 1/0", ramWEN, ramREN);
        end
        n_cmp++;
        if (ramstore !== 32'h1234 || ramaddr !== 32'h80) begin
            n_err++;
            $display("FAIL prio_bus: got st=%h ad=%h want 1234/80",
                     ramstore, ramaddr);
        end
        n_cmp++;
        if (dwait !== 1'b0 || iwait !== 1'b1) begin
            n_err++;
            $display("FAIL prio_wait: got d=%b i=%b want 0/1", dwait, iwait);
        end
        dWEN = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 2'b00) begin
            n_err++;
            $display("FAIL prio_idle: got %b want 00", grant);
        end
        tick();
        n_cmp++;
        if (grant !== 2'b01 || ramaddr !== 32'h44) begin
            n_err++;
            $display("FAIL prio_ignt: got g=%b ad=%h want 01/44", grant, ramaddr);
        end
        iREN = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_busy();
        dREN     = 1'b1;
        daddr    = 32'h100;
        ramstate = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (grant !== 2'b10 || dwait !== 1'b1) begin
                n_err++;
                $display("FAIL busy_hold%0d: got g=%b dw=%b want 10/1",
                         i, grant, dwait);
            end
            n_cmp++;
            if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin
                n_err++;
                $display("FAIL busy_ram%0d: got ren=%b ad=%h want 1/100",
                         i, ramREN, ramaddr);
            end
        end
        ramstate = 2'd2;
        #1;
        n_cmp++;
        if (dwait !== 1'b0 || ramREN !== 1'b1) begin
            n_err++;
            $display("FAIL busy_done: got dw=%b ren=%b want 0/1", dwait, ramREN);
        end
        dREN = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 2'b00) begin
            n_err++;
            $display("FAIL busy_idle: got %b want 00", grant);
        end
    endtask

    task automatic test_hold_states();
        logic [1:0] st [3];
        st[0] = 2'd3;
        st[1] = 2'd0;
        st[2] = 2'd1;
        iREN  = 1'b1;
        iaddr = 32'h200;
        dREN  = 1'b0;
        ramstate = 2'd3;
        tick();
        for (int i = 0; i < 3; i++) begin
            ramstate = st[i];
            tick();
            n_cmp++;
            if (grant !== 2'b01 || iwait !== 1'b1 || ramREN !== 1'b1) begin
                n_err++;
                $display("FAIL hold_st%0d: got g=%b iw=%b ren=%b want 01/1/1",
                         st[i], grant, iwait, ramREN);
            end
        end
        iREN = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        dREN     = 1'b1;
        dWEN     = 1'b1;
        daddr    = 32'h300;
        dstore   = 32'hCAFE;
        ramstate = 2'd1;
        tick();
        n_cmp++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin
            n_err++;
            $display("FAIL abort_rw: got wen=%b ren=%b want 1/0", ramWEN, ramREN);
        end
        dWEN = 1'b0;
        #1;
        n_cmp++;
        if (ramWEN !== 1'b0 || ramREN !== 1'b1) begin
            n_err++;
            $display("FAIL abort_rd: got wen=%b ren=%b want 0/1", ramWEN, ramREN);
        end
        dREN = 1'b0;
        #1;
        n_cmp++;
        if (ramWEN !== 1'b0 || ramREN !== 1'b0 || grant !== 2'b10) begin
            n_err++;
            $display("FAIL abort_drop: got wen=%b ren=%b g=%b want 0/0/10",
                     ramWEN, ramREN, grant);
        end
        tick();
        n_cmp++;
        if (grant !== 2'b00) begin
            n_err++;
            $display("FAIL abort_idle: got %b want 00", grant);
        end
    endtask

    task automatic test_reset_mid();
        iREN     = 1'b1;
        iaddr    = 32'h400;
        ramstate = 2'd1;
        tick();
        n_cmp++;
        if (grant !== 2'b01) begin
            n_err++;
            $display("FAIL rmid_ignt: got %b want 01", grant);
        end
        RST = 1'b1;
        tick();
        n_cmp++;
        if (grant !== 2'b00 || ramREN !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_state: got g=%b ren=%b want 00/0", grant, ramREN);
        end
        n_cmp++;
        if (iwait !== 1'b1 || dwait !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_wait: got i=%b d=%b want 1/1", iwait, dwait);
        end
        RST  = 1'b0;
        iREN = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        int  dgr;
        bit  iseen;
        int  exp_dgr;
        bit  exp_iseen;
`ifdef ARB_STARVE_GUARD_EN
        exp_dgr   = 4;
        exp_iseen = 1'b1;
`else
        exp_dgr   = 10;
        exp_iseen = 1'b0;
`endif
        dgr   = 0;
        iseen = 1'b0;
        idle_inputs();
        RST = 1'b1;
        tick();
        RST      = 1'b0;
        iREN     = 1'b1;
        iaddr    = 32'h500;
        dREN     = 1'b1;
        daddr    = 32'h600;
        ramstate = 2'd2;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant == 2'b01) begin
                iseen = 1'b1;
            end else if (grant == 2'b10 && !iseen) begin
                dgr++;
            end
        end
        n_cmp++;
        if (iseen !== exp_iseen) begin
            n_err++;
            $display("FAIL starve_ignt: got %b want %b", iseen, exp_iseen);
        end
        n_cmp++;
        if (dgr != exp_dgr) begin
            n_err++;
            $display("FAIL starve_dcount: got %0d want %0d", dgr, exp_dgr);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST   = 1'b1;
        idle_inputs();
        test_reset();
        test_iread();
        test_priority();
        test_busy();
        test_hold_states();
        test_abort();
        test_reset_mid();
        test_starve();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
